sort_stream_ctrl: RTL and testbench
===================================

# sort_stream_ctrl

- Stream-side controller in front of `gnome_sort_engine`.
- Accepts one packet of words on a valid/ready input stream and writes them into the engine.
- Starts the sort, waits for completion, then reads the sorted words back and emits them on a valid/ready output stream with a last flag.
- Acts as the initiator for the engine's load/run/read port, so the rest of the design never sequences the engine directly.

## Interface
- `AWIDTH`, 5: engine address width; packet capacity is 2**AWIDTH words.
- `DWIDTH`, 8: data width.
- `ODEPTH`, 4: output FIFO depth (power of two, ≥4).

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `s_data_i`  in  DWIDTH  input word.
- `s_valid_i`  in  1  input word valid.
- `s_last_i`  in  1  final word of the packet.
- `s_ready_o`  out  1  input accepted when valid&&ready.
- `m_data_o`  out  DWIDTH  sorted word.
- `m_valid_o`  out  1  output valid.
- `m_last_o`  out  1  final sorted word.
- `m_ready_i`  in  1  downstream ready.
- `eng_srst_o`  out  1  to engine `srst_i`.
- `eng_run_o`  out  1  to engine `run_i`.
- `eng_wr_req_o`  out  1  to engine `wr_req_i`.
- `eng_wr_data_o`  out  DWIDTH  to engine `wr_data_i`.
- `eng_rd_req_o`  out  1  to engine `rd_req_i`.
- `eng_rd_data_i`  in  DWIDTH  from engine `rd_data_o`.
- `eng_done_i`  in  1  from engine `done_o`, sticky until srst.
- `busy_o`  out  1  state != IDLE.
- `trunc_o`  out  1  one-cycle pulse when a packet is closed at capacity without `s_last_i`.

## Operation
State machine: IDLE → CLEAR → LOAD → RUN → WAIT → DRAIN → IDLE.

- **IDLE**
  - `s_ready_o`=0.
  - `s_valid_i`=1 → CLEAR.
- **CLEAR**
  - `eng_srst_o`=1 for exactly one cycle → LOAD.
  - Clear word count `cnt` (AWIDTH+1 bits), read count `rcnt`, and in-flight flag.
- **LOAD**
  - `s_ready_o`=1.
  - `eng_wr_req_o` = `s_valid_i`&&`s_ready_o`; `eng_wr_data_o` = `s_data_i` (combinational).
  - Each handshake increments `cnt`.
  - A handshake with `s_last_i`=1 → RUN.
  - A handshake that makes `cnt` = 2**AWIDTH → RUN and pulses `trunc_o`. Later input words start the next packet; their `s_last_i` closes that packet.
- **RUN**
  - `eng_run_o`=1 for one cycle → WAIT.
- **WAIT**
  - `eng_done_i`=1 → DRAIN.
- **DRAIN**
  - Assert `eng_rd_req_o` while `rcnt` < `cnt` and (FIFO occupancy + in-flight) < ODEPTH; increment `rcnt` per request.
  - `eng_rd_data_i` is valid one cycle after its request and is pushed into the output FIFO.
  - Each pushed word is tagged last when it is word `cnt`-1.
  - Pop of the last-tagged word (`m_valid_o`&&`m_ready_i`&&`m_last_o`) → IDLE.
- Output order is ascending: the engine swaps while mem[i] < mem[i-1].
- `eng_*` outputs are 0 in every state that does not drive them.

## Timing
- Reset value of every output is 0. Async `rst_i` mid-packet returns to IDLE and empties the FIFO. The engine must be reset alongside.
- Load: one word per cycle, no bubbles.
- End of packet: RUN one cycle after the last handshake; WAIT the cycle after RUN.
- Read latency: `eng_rd_req_o` at cycle n → FIFO write at n+1 → `m_valid_o` at n+2 (registered FIFO output).
- Drain throughput: with `m_ready_i` held high, one word per cycle after the 2-cycle latency.
- Backpressure: `m_ready_i`=0 stalls requests once credits run out. No word is lost, and `m_data_o`/`m_last_o` are stable while `m_valid_o`&&!`m_ready_i`.
- `s_valid_i` arriving during WAIT/DRAIN is held off (`s_ready_o`=0) until the next LOAD.
- Single-word packet: a complete cycle; `m_last_o`=1 on the only word.

## Structure
- `sort_engine_pkg`: state enum `sort_ctrl_state_t`, and a capacity constant function of AWIDTH.
- Sub-module `sort_out_fifo`: synchronous FIFO, ODEPTH×(DWIDTH+1), registered output, provides occupancy.
- Top instantiates `sort_out_fifo` only. The engine is instantiated beside it by the parent.

## Test plan
- Packet {5,3,9,1} with last on 1 → output 1,3,5,9, `m_last_o` on 9, one `eng_srst_o` and one `eng_run_o` pulse.
- Single word 0x7F with last → output 0x7F with `m_last_o`=1, FIFO empty, back to IDLE.
- 33 words, AWIDTH=5, no last until word 33 → first packet of 32 sorted words with `trunc_o` pulsed once; second packet is the single word 33.
- `m_ready_i` toggling 1-0-0-1 during DRAIN of 8 reverse-ordered words → 0..7 in order, no drops or duplicates, data held while stalled.
- Two back-to-back packets {2,2,1} and {0xFF,0} → 1,2,2 then 0,0xFF; second CLEAR occurs only after the first `m_last_o` pop.
- `rst_i` asserted during WAIT → all outputs 0 immediately; the next packet {4,2} sorts to 2,4.

Source files
------------

// File: rtl/sort_engine_pkg.sv
// ---------------------------------------------------------------------------
// sort_engine_pkg
//   Shared types and helpers for the stream-side sort controller.
//   - sort_ctrl_state_t : controller FSM states
//   - sort_capacity()   : packet capacity in words for a given address width
// ---------------------------------------------------------------------------
package sort_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DRAIN = 3'd5
    } sort_ctrl_state_t;

    function automatic int unsigned sort_capacity(input int unsigned awidth);
        return 32'd1 << awidth;
    endfunction

endpackage

// File: rtl/sort_out_fifo.sv
// ---------------------------------------------------------------------------
// sort_out_fifo
//   Synchronous FIFO, DEPTH x WIDTH. Read data comes straight from storage
//   flops (no combinational path from push to the output), so a word pushed
//   at the end of cycle n is visible at cycle n+1.
//   Ports:
//     clk_i, rst_i   clock, async active-high reset (empties the FIFO)
//     push_i/data_i  write one word (caller guarantees not full)
//     pop_i          consume head word (ignored when empty)
//     data_o/valid_o head word and its valid flag
//     occ_o          current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sort_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   occ_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && (count != FULL);
    assign do_pop  = pop_i && (count != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: valid_o masks it until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= data_i;
    end

    assign data_o  = mem[rptr];
    assign valid_o = (count != '0);
    assign occ_o   = count;

endmodule

// File: rtl/sort_stream_ctrl.sv
// ---------------------------------------------------------------------------
// sort_stream_ctrl
//   Stream front end for gnome_sort_engine. Loads one packet from the input
//   stream into the engine, runs the sort, then reads the words back through
//   a small credit-controlled FIFO onto the output stream with a last flag.
//   Ports:
//     clk_i, rst_i                     clock, async active-high reset
//     s_data_i/s_valid_i/s_last_i      input packet stream
//     s_ready_o                        input ready (LOAD only)
//     m_data_o/m_valid_o/m_last_o      sorted output stream
//     m_ready_i                        downstream ready
//     eng_srst_o/eng_run_o             engine clear and start pulses
//     eng_wr_req_o/eng_wr_data_o       engine load port
//     eng_rd_req_o/eng_rd_data_i       engine read port (data one cycle later)
//     eng_done_i                       engine finished (sticky until srst)
//     busy_o                           controller not idle
//     trunc_o                          packet closed at capacity without last
// ---------------------------------------------------------------------------
module sort_stream_ctrl
    import sort_engine_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int ODEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DWIDTH-1:0] s_data_i,
    input  logic              s_valid_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    output logic [DWIDTH-1:0] m_data_o,
    output logic              m_valid_o,
    output logic              m_last_o,
    input  logic              m_ready_i,
    output logic              eng_srst_o,
    output logic              eng_run_o,
    output logic              eng_wr_req_o,
    output logic [DWIDTH-1:0] eng_wr_data_o,
    output logic              eng_rd_req_o,
    input  logic [DWIDTH-1:0] eng_rd_data_i,
    input  logic              eng_done_i,
    output logic              busy_o,
    output logic              trunc_o
);

    localparam int NW  = AWIDTH + 1;
    localparam int OCW = $clog2(ODEPTH) + 1;
    localparam logic [NW-1:0]  CAP   = NW'(sort_capacity(AWIDTH));
    localparam logic [NW-1:0]  ONE   = NW'(1);
    localparam logic [OCW:0]   OLIM  = (OCW+1)'(ODEPTH);

    sort_ctrl_state_t state, state_n;

    logic [NW-1:0]  cnt;
    logic [NW-1:0]  rcnt;
    logic [NW-1:0]  cnt_inc;
    logic           inflight;
    logic           inflight_last;
    logic           load_hs;
    logic           at_cap;

    logic [DWIDTH:0] fifo_dout;
    logic            fifo_valid;
    logic [OCW-1:0]  fifo_occ;
    logic [OCW:0]    used;
    logic            pop;
    logic            pop_last;

    assign cnt_inc  = cnt + ONE;
    assign at_cap   = (cnt_inc == CAP);
    assign load_hs  = s_valid_i && s_ready_o;
    assign pop      = fifo_valid && m_ready_i;
    assign pop_last = pop && fifo_dout[DWIDTH];
    // Credits: words already queued plus the one whose data lands next cycle.
    assign used     = {1'b0, fifo_occ} + {{OCW{1'b0}}, inflight};

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_n;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (s_valid_i) state_n = ST_CLEAR;
            ST_CLEAR: state_n = ST_LOAD;
            ST_LOAD:  if (load_hs && (s_last_i || at_cap)) state_n = ST_RUN;
            ST_RUN:   state_n = ST_WAIT;
            ST_WAIT:  if (eng_done_i) state_n = ST_DRAIN;
            ST_DRAIN: if (pop_last) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        s_ready_o     = 1'b0;
        eng_srst_o    = 1'b0;
        eng_run_o     = 1'b0;
        eng_wr_req_o  = 1'b0;
        eng_wr_data_o = '0;
        eng_rd_req_o  = 1'b0;
        trunc_o       = 1'b0;
        case (state)
            ST_CLEAR: eng_srst_o = 1'b1;
            ST_LOAD: begin
                s_ready_o     = 1'b1;
                eng_wr_req_o  = s_valid_i;
                eng_wr_data_o = s_data_i;
                // Capacity reached on a word that did not carry last.
                trunc_o       = s_valid_i && !s_last_i && at_cap;
            end
            ST_RUN:   eng_run_o = 1'b1;
            ST_DRAIN: eng_rd_req_o = (rcnt < cnt) && (used < OLIM);
            default: ;
        endcase
    end

    assign busy_o = (state != ST_IDLE);

    // ---------------- counters / read pipeline ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt           <= '0;
            rcnt          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= eng_rd_req_o;
            inflight_last <= eng_rd_req_o && (rcnt == cnt - ONE);
            if (state == ST_CLEAR) begin
                cnt  <= '0;
                rcnt <= '0;
            end else begin
                if (load_hs)      cnt  <= cnt_inc;
                if (eng_rd_req_o) rcnt <= rcnt + ONE;
            end
        end
    end

    // Engine read data arrives one cycle after its request and goes straight
    // into the FIFO together with its last tag.
    sort_out_fifo #(
        .DEPTH (ODEPTH),
        .WIDTH (DWIDTH + 1)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (inflight),
        .data_i  ({inflight_last, eng_rd_data_i}),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .valid_o (fifo_valid),
        .occ_o   (fifo_occ)
    );

    // Mask stale storage so idle outputs read as zero.
    assign m_valid_o = fifo_valid;
    assign m_data_o  = fifo_valid ? fifo_dout[DWIDTH-1:0] : '0;
    assign m_last_o  = fifo_valid && fifo_dout[DWIDTH];

endmodule

// File: tb/tb_sort_stream_ctrl.sv
module tb_sort_stream_ctrl;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int OD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0] s_data;
    logic          s_valid, s_last, s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid, m_last, m_ready;
    logic          eng_srst, eng_run, eng_wr, eng_rd;
    logic [DW-1:0] eng_wr_data, eng_rd_data;
    logic          eng_done;
    logic          busy, trunc;

    sort_stream_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .ODEPTH(OD)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready),
        .m_data_o(m_data), .m_valid_o(m_valid), .m_last_o(m_last), .m_ready_i(m_ready),
        .eng_srst_o(eng_srst), .eng_run_o(eng_run), .eng_wr_req_o(eng_wr),
        .eng_wr_data_o(eng_wr_data), .eng_rd_req_o(eng_rd), .eng_rd_data_i(eng_rd_data),
        .eng_done_i(eng_done), .busy_o(busy), .trunc_o(trunc)
    );

    // ---------------- behavioural engine ----------------
    typedef logic [DW-1:0] mem_t [32];
    mem_t em;
    int   ewp, erp, etmr;

    function automatic mem_t sort_mem(input mem_t m, input int n);
        mem_t r = m;
        for (int i = 1; i < n; i++) begin
            for (int j = i; j > 0 && r[j] < r[j-1]; j--) begin
                logic [DW-1:0] t = r[j];
                r[j] = r[j-1];
                r[j-1] = t;
            end
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || eng_srst) begin
            ewp <= 0; erp <= 0; etmr <= 0; eng_done <= 1'b0;
            if (rst) eng_rd_data <= '0;
        end else begin
            if (eng_wr && ewp < 32) begin
                em[ewp] <= eng_wr_data;
                ewp     <= ewp + 1;
            end
            if (eng_run) etmr <= 8;
            else if (etmr == 1) begin
                em <= sort_mem(em, ewp);
                eng_done <= 1'b1;
                etmr <= 0;
            end else if (etmr > 1) etmr <= etmr - 1;
            if (eng_rd) begin
                eng_rd_data <= em[erp[4:0]];
                erp <= erp + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- monitor (negedge) ----------------
    int cyc = 0, srst_cnt = 0, run_cnt = 0, trunc_cnt = 0;
    int srst_cyc[$];
    logic       hv = 1'b0;
    logic [8:0] hd;

    always @(negedge clk) begin
        cyc++;
        if (eng_srst) begin srst_cnt++; srst_cyc.push_back(cyc); end
        if (eng_run)  run_cnt++;
        if (trunc)    trunc_cnt++;
        if (hv && m_valid) chk("hold_stable", {m_last, m_data}, hd);
        hv = m_valid && !m_ready;
        hd = {m_last, m_data};
    end

    // ---------------- stimulus helpers ----------------
    logic [DW-1:0] in_d[$];
    bit            in_l[$];
    logic [DW-1:0] exp_d[$], got_d[$];
    bit            exp_l[$], got_l[$];
    logic [3:0]    rdy_pat = 4'hF;
    int            first_last_cyc;

    task automatic send_words();
        for (int i = 0; i < in_d.size(); i++) begin
            int t = 0;
            bit acc = 0;
            s_data = in_d[i]; s_last = in_l[i]; s_valid = 1'b1;
            while (!acc && t < 2000) begin
                @(negedge clk); acc = s_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) chk("accept_timeout", 0, 1);
        end
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    endtask

    task automatic collect(input int nlast);
        int seen = 0;
        int t = 0;
        while (seen < nlast && t < 3000) begin
            @(posedge clk); #1;
            m_ready = rdy_pat[t % 4];
            @(negedge clk);
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
                if (m_last) begin
                    seen++;
                    if (seen == 1) first_last_cyc = cyc;
                end
            end
            t++;
        end
        if (seen < nlast) chk("drain_timeout", 64'(seen), 64'(nlast));
        @(posedge clk); #1;
        m_ready = 1'b0;
    endtask

    task automatic start_test();
        in_d.delete(); in_l.delete(); exp_d.delete(); exp_l.delete();
        got_d.delete(); got_l.delete();
        srst_cnt = 0; run_cnt = 0; trunc_cnt = 0; srst_cyc.delete();
        first_last_cyc = 0;
    endtask

    task automatic run_and_check(input string tag, input int nlast);
        fork
            send_words();
            collect(nlast);
        join
        chk({tag, "_count"}, 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            chk($sformatf("%s_d%0d", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
            chk($sformatf("%s_l%0d", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {busy, trunc, s_ready, m_valid, m_last, m_data,
             eng_srst, eng_run, eng_wr, eng_wr_data, eng_rd}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // {5,3,9,1} -> 1,3,5,9
        start_test();
        in_d = '{8'd5, 8'd3, 8'd9, 8'd1}; in_l = '{0, 0, 0, 1};
        exp_d = '{8'd1, 8'd3, 8'd5, 8'd9}; exp_l = '{0, 0, 0, 1};
        run_and_check("p4", 1);
        chk("p4_srst_pulses", 64'(srst_cnt), 1);
        chk("p4_run_pulses", 64'(run_cnt), 1);
        chk("p4_trunc", 64'(trunc_cnt), 0);

        // single word
        start_test();
        in_d = '{8'h7F}; in_l = '{1};
        exp_d = '{8'h7F}; exp_l = '{1};
        run_and_check("single", 1);
        @(negedge clk);
        chk("single_idle", {busy, m_valid}, 0);

        // 33 words: truncation at 32, then a one-word packet
        start_test();
        for (int i = 0; i < 32; i++) begin in_d.push_back(8'(31 - i)); in_l.push_back(0); end
        in_d.push_back(8'hAA); in_l.push_back(1);
        for (int i = 0; i < 32; i++) begin exp_d.push_back(8'(i)); exp_l.push_back(i == 31); end
        exp_d.push_back(8'hAA); exp_l.push_back(1);
        run_and_check("trunc", 2);
        chk("trunc_pulses", 64'(trunc_cnt), 1);
        chk("trunc_srst_pulses", 64'(srst_cnt), 2);

        // backpressure 1-0-0-1 on 8 reversed words
        start_test();
        rdy_pat = 4'b1001;
        for (int i = 0; i < 8; i++) begin in_d.push_back(8'(7 - i)); in_l.push_back(i == 7); end
        for (int i = 0; i < 8; i++) begin exp_d.push_back(8'(i)); exp_l.push_back(i == 7); end
        run_and_check("bp", 1);
        rdy_pat = 4'hF;

        // back-to-back {2,2,1} and {FF,0}
        start_test();
        in_d = '{8'd2, 8'd2, 8'd1, 8'hFF, 8'h00}; in_l = '{0, 0, 1, 0, 1};
        exp_d = '{8'd1, 8'd2, 8'd2, 8'h00, 8'hFF}; exp_l = '{0, 0, 1, 0, 1};
        run_and_check("b2b", 2);
        chk("b2b_srst_pulses", 64'(srst_cnt), 2);
        if (srst_cyc.size() == 2)
            chk("b2b_clear_after_pop", 64'(srst_cyc[1] > first_last_cyc), 1);

        // reset during WAIT
        start_test();
        in_d = '{8'd9, 8'd8}; in_l = '{0, 1};
        send_words();
        begin
            int t = 0;
            while (run_cnt == 0 && t < 200) begin @(negedge clk); t++; end
            chk("wait_reached", 64'(run_cnt), 1);
        end
        @(negedge clk); @(negedge clk);
        chk("in_wait_busy", 64'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_outputs", {busy, trunc, s_ready, m_valid, m_last, m_data,
             eng_srst, eng_run, eng_wr, eng_wr_data, eng_rd}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        start_test();
        in_d = '{8'd4, 8'd2}; in_l = '{0, 1};
        exp_d = '{8'd2, 8'd4}; exp_l = '{0, 1};
        run_and_check("after_rst", 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
